// File: rtl/issue_queue_pkg.sv
// Shared constants and types for the issue queue.
// Defines the default queue depth, RoB tag width, opcode width and operand
// width, plus the CDB match result type used during wakeup and dispatch.
package issue_queue_pkg;

    localparam int IQ_DEPTH  = 8;
    localparam int IQ_ROB_W  = 4;
    localparam int IQ_OP_W   = 6;
    localparam int IQ_DATA_W = 32;

    typedef struct packed {
        logic                 hit;
        logic [IQ_DATA_W-1:0] val;
    } cdb_hit_t;

endpackage

// File: rtl/issue_queue_select.sv
// iq_select: combinational one-of-N picker shared by free-slot and issue
// selection.
// Ports:
//   req_i   [N]          request bits
//   age_i   [N][AGE_W]   per-entry ages (only looked at when AGE_EN=1)
//   valid_o              at least one request present
//   idx_o                chosen index: lowest set bit, or the largest age
//                        with ties going to the lowest index when AGE_EN=1
module iq_select #(
    parameter int N      = 8,
    parameter int AGE_W  = 3,
    parameter bit AGE_EN = 1'b0
) (
    input  logic [N-1:0]            req_i,
    input  logic [N-1:0][AGE_W-1:0] age_i,
    output logic                    valid_o,
    output logic [$clog2(N)-1:0]    idx_o
);

    localparam int IDX_W = $clog2(N);

    // Scanning upward with a strict '>' keeps the lowest index on age ties.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                if (!valid_o || (AGE_EN && (age_i[i] > age_i[idx_o]))) begin
                    valid_o = 1'b1;
                    idx_o   = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: out-of-order ALU issue queue with CDB wakeup.
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global enable)
//   iq_full, iq_count        occupancy status
//   inst_*                   dispatch request with operand values/dependencies
//   flush                    misprediction clear, overrides rdy_in
//   alu_ready, issue_*       registered issue port
//   cdb0_*, cdb1_*           result broadcasts (cdb0 wins on equal tags)
// Build option: define IQ_AGE_ORDER_EN to issue the oldest ready entry;
// otherwise the lowest-index ready entry issues and no age state exists.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int ROB_W = IQ_ROB_W,
    parameter int OP_W  = IQ_OP_W
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    output logic                       iq_full,
    output logic [$clog2(DEPTH):0]     iq_count,
    input  logic                       inst_valid,
    input  logic [OP_W-1:0]            inst_op,
    input  logic [ROB_W-1:0]           inst_robid,
    input  logic [IQ_DATA_W-1:0]       inst_val1,
    input  logic [IQ_DATA_W-1:0]       inst_val2,
    input  logic                       inst_has_rely1,
    input  logic                       inst_has_rely2,
    input  logic [ROB_W-1:0]           inst_rely1,
    input  logic [ROB_W-1:0]           inst_rely2,
    input  logic                       flush,
    input  logic                       alu_ready,
    output logic                       issue_valid,
    output logic [OP_W-1:0]            issue_op,
    output logic [IQ_DATA_W-1:0]       issue_rs1,
    output logic [IQ_DATA_W-1:0]       issue_rs2,
    output logic [ROB_W-1:0]           issue_robid,
    input  logic                       cdb0_valid,
    input  logic                       cdb1_valid,
    input  logic [ROB_W-1:0]           cdb0_robid,
    input  logic [ROB_W-1:0]           cdb1_robid,
    input  logic [IQ_DATA_W-1:0]       cdb0_val,
    input  logic [IQ_DATA_W-1:0]       cdb1_val
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int AGE_W = IDX_W;
`ifdef IQ_AGE_ORDER_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    logic [DEPTH-1:0]     busy_q, busy_d, q1_q, q1_d, q2_q, q2_d;
    logic [OP_W-1:0]      op_q    [DEPTH], op_d    [DEPTH];
    logic [ROB_W-1:0]     robid_q [DEPTH], robid_d [DEPTH];
    logic [ROB_W-1:0]     t1_q    [DEPTH], t1_d    [DEPTH];
    logic [ROB_W-1:0]     t2_q    [DEPTH], t2_d    [DEPTH];
    logic [IQ_DATA_W-1:0] v1_q    [DEPTH], v1_d    [DEPTH];
    logic [IQ_DATA_W-1:0] v2_q    [DEPTH], v2_d    [DEPTH];
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 issue_valid_q, issue_valid_d;
    logic [OP_W-1:0]      issue_op_q, issue_op_d;
    logic [IQ_DATA_W-1:0] issue_rs1_q, issue_rs1_d, issue_rs2_q, issue_rs2_d;
    logic [ROB_W-1:0]     issue_robid_q, issue_robid_d;

    logic [DEPTH-1:0][AGE_W-1:0] sel_age;
`ifdef IQ_AGE_ORDER_EN
    logic [DEPTH-1:0][AGE_W-1:0] age_q, age_d;
    assign sel_age = age_q;
`else
    assign sel_age = '0;
`endif

    logic [DEPTH-1:0] ready;
    logic             rdy_vld, free_vld, do_iss, do_disp;
    logic [IDX_W-1:0] rdy_idx, free_idx;

    // Both pickers see only pre-edge state, so a slot freed by this cycle's
    // issue cannot be handed to this cycle's dispatch.
    assign ready = busy_q & ~q1_q & ~q2_q;

    iq_select #(.N(DEPTH), .AGE_W(AGE_W), .AGE_EN(AGE_EN)) u_sel_issue (
        .req_i   (ready),
        .age_i   (sel_age),
        .valid_o (rdy_vld),
        .idx_o   (rdy_idx)
    );

    iq_select #(.N(DEPTH), .AGE_W(AGE_W), .AGE_EN(1'b0)) u_sel_free (
        .req_i   (~busy_q),
        .age_i   ('0),
        .valid_o (free_vld),
        .idx_o   (free_idx)
    );

    assign do_iss  = alu_ready && rdy_vld;
    assign do_disp = inst_valid && free_vld;

    function automatic cdb_hit_t cdb_match(input logic [ROB_W-1:0] tag);
        if (cdb0_valid && (cdb0_robid == tag)) return '{hit: 1'b1, val: cdb0_val};
        if (cdb1_valid && (cdb1_robid == tag)) return '{hit: 1'b1, val: cdb1_val};
        return '0;
    endfunction

    always_comb begin
        cdb_hit_t h1, h2;
        h1      = '0;
        h2      = '0;
        busy_d  = busy_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        op_d    = op_q;
        robid_d = robid_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
`ifdef IQ_AGE_ORDER_EN
        age_d   = age_q;
`endif
        count_d       = count_q;
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_rs1_d   = issue_rs1_q;
        issue_rs2_d   = issue_rs2_q;
        issue_robid_d = issue_robid_q;

        if (flush) begin
            busy_d        = '0;
            count_d       = '0;
            issue_valid_d = 1'b0;
            issue_op_d    = '0;
            issue_rs1_d   = '0;
            issue_rs2_d   = '0;
            issue_robid_d = '0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                h1 = cdb_match(t1_q[i]);
                h2 = cdb_match(t2_q[i]);
                if (busy_q[i] && q1_q[i] && h1.hit) begin
                    q1_d[i] = 1'b0;
                    v1_d[i] = h1.val;
                end
                if (busy_q[i] && q2_q[i] && h2.hit) begin
                    q2_d[i] = 1'b0;
                    v2_d[i] = h2.val;
                end
            end

            issue_valid_d = 1'b0;
            issue_op_d    = '0;
            issue_rs1_d   = '0;
            issue_rs2_d   = '0;
            issue_robid_d = '0;
            if (do_iss) begin
                issue_valid_d    = 1'b1;
                issue_op_d       = op_q[rdy_idx];
                issue_rs1_d      = v1_q[rdy_idx];
                issue_rs2_d      = v2_q[rdy_idx];
                issue_robid_d    = robid_q[rdy_idx];
                busy_d[rdy_idx]  = 1'b0;
            end

            if (do_disp) begin
`ifdef IQ_AGE_ORDER_EN
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy_q[i] && (age_q[i] != AGE_W'(DEPTH - 1)))
                        age_d[i] = age_q[i] + 1'b1;
                end
                age_d[free_idx] = '0;
`endif
                h1 = cdb_match(inst_rely1);
                h2 = cdb_match(inst_rely2);
                busy_d[free_idx]  = 1'b1;
                op_d[free_idx]    = inst_op;
                robid_d[free_idx] = inst_robid;
                t1_d[free_idx]    = inst_rely1;
                t2_d[free_idx]    = inst_rely2;
                q1_d[free_idx]    = inst_has_rely1 && !h1.hit;
                q2_d[free_idx]    = inst_has_rely2 && !h2.hit;
                v1_d[free_idx]    = (inst_has_rely1 && h1.hit) ? h1.val : inst_val1;
                v2_d[free_idx]    = (inst_has_rely2 && h2.hit) ? h2.val : inst_val2;
            end

            count_d = count_q + CNT_W'(do_disp) - CNT_W'(do_iss);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q        <= '0;
            q1_q          <= '0;
            q2_q          <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_rs1_q   <= '0;
            issue_rs2_q   <= '0;
            issue_robid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]    <= '0;
                robid_q[i] <= '0;
                t1_q[i]    <= '0;
                t2_q[i]    <= '0;
                v1_q[i]    <= '0;
                v2_q[i]    <= '0;
            end
`ifdef IQ_AGE_ORDER_EN
            age_q <= '0;
`endif
        end else begin
            busy_q        <= busy_d;
            q1_q          <= q1_d;
            q2_q          <= q2_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_rs1_q   <= issue_rs1_d;
            issue_rs2_q   <= issue_rs2_d;
            issue_robid_q <= issue_robid_d;
            op_q          <= op_d;
            robid_q       <= robid_d;
            t1_q          <= t1_d;
            t2_q          <= t2_d;
            v1_q          <= v1_d;
            v2_q          <= v2_d;
`ifdef IQ_AGE_ORDER_EN
            age_q <= age_d;
`endif
        end
    end

    assign iq_count    = count_q;
    assign iq_full     = (count_q == CNT_W'(DEPTH));
    assign issue_valid = issue_valid_q;
    assign issue_op    = issue_op_q;
    assign issue_rs1   = issue_rs1_q;
    assign issue_rs2   = issue_rs2_q;
    assign issue_robid = issue_robid_q;

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, number of entries (power of two, 2..32).
REQ-002 SHALL provide parameter ROB_W, default 4, width of a RoB tag.
REQ-003 SHALL provide parameter OP_W, default 6, width of the ALU opcode.
REQ-004 SHALL provide ports, in this order:
- clk_in  in  1  clock, single domain
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- iq_full  out  1  high when no free entry
- iq_count  out  clog2(DEPTH)+1  number of occupied entries
- inst_valid  in  1  dispatch request
- inst_op  in  OP_W  opcode
- inst_robid  in  ROB_W  destination RoB tag
- inst_val1, inst_val2  in  32  operand values
- inst_has_rely1, inst_has_rely2  in  1  operand pending
- inst_rely1, inst_rely2  in  ROB_W  producer tags
- flush  in  1  misprediction clear
- alu_ready  in  1  ALU accepts an issue this cycle
- issue_valid  out  1  issue strobe
- issue_op  out  OP_W  opcode
- issue_rs1, issue_rs2  out  32  operands
- issue_robid  out  ROB_W  tag
- cdb0_valid, cdb1_valid  in  1  broadcast valid (ALU, LSB)
- cdb0_robid, cdb1_robid  in  ROB_W  broadcast tags
- cdb0_val, cdb1_val  in  32  broadcast values

Function
REQ-005 Each entry SHALL hold busy, op, robid, v1, v2, q1/q2 pending flags, q1/q2 tags and an age field.
REQ-006 iq_full SHALL be combinational: iq_count == DEPTH; iq_count SHALL be registered.
REQ-007 Dispatch with inst_valid=1 and a free entry SHALL write the lowest-index free entry, determined from state before this edge; slots freed by an issue this cycle SHALL NOT be reused in the same cycle.
REQ-008 Dispatch while iq_full SHALL be silently dropped; iq_count SHALL stay at DEPTH.
REQ-009 At dispatch, an operand whose tag matches a valid CDB broadcast in the same cycle SHALL be captured as ready with the broadcast value; cdb0 SHALL take priority over cdb1 if both match.
REQ-010 Each cycle, every busy entry with a pending operand matching a valid CDB tag SHALL clear its flag and latch the value; both operands SHALL be able to wake in the same cycle from different ports.
REQ-011 An entry SHALL be ready when it is busy and both pending flags are clear; a value woken at edge N SHALL make the entry eligible to issue at edge N+1.
REQ-012 When alu_ready=1 and at least one entry is ready, one entry SHALL be selected per REQ-019; the issue_* outputs SHALL be registered with issue_valid=1 on the next edge; the entry SHALL be freed at that edge.
REQ-013 When alu_ready=0 or no entry is ready, issue_valid SHALL be 0 next cycle, issue_* data SHALL be 0, and no entry SHALL be freed.
REQ-014 Dispatch and issue in the same cycle SHALL both take effect: iq_count +1 -1 = unchanged.
REQ-015 At dispatch, the new entry's age SHALL be 0 and every other busy entry's age SHALL increment, saturating at DEPTH-1; issue SHALL NOT change ages.
REQ-016 flush=1 SHALL clear all busy bits and iq_count, force issue_valid=0 and discard any same-cycle dispatch; flush SHALL take priority over rdy_in.

Reset
REQ-017 rst_in=1 at a clock edge SHALL clear all entries, iq_count, issue_valid and all issue_* data, regardless of rdy_in.
REQ-018 Reset asserted mid-operation SHALL discard pending wakeups and issues; the first dispatch after release SHALL go to entry 0.

Configuration
REQ-019 With IQ_AGE_ORDER_EN defined, selection SHALL pick the ready entry with the largest age, breaking ties by lowest index; without it, selection SHALL pick the lowest-index ready entry, and the age fields SHALL NOT be synthesised.

Structure
REQ-020 The shared constants package/include SHALL define the default IQ_DEPTH, RoB tag width and opcode width; the block SHALL NOT define them locally.
REQ-021 Ready/free/oldest selection SHALL live in a single combinational sub-module iq_select: it takes DEPTH request bits plus optional ages and returns a valid flag and an index.

Verification
REQ-022 Reset, then dispatch op=3 robid=5 val1=10 val2=20 with no deps; alu_ready=1 -> issue_valid=1 two edges later with rs1=10, rs2=20, robid=5; iq_count returns to 0.
REQ-023 Dispatch robid=2 with rely1=7 pending; cdb1 broadcasts tag 7, val 0xDEAD -> next cycle issue_rs1=0xDEAD; a same-cycle broadcast with dispatch yields an identical result.
REQ-024 Fill DEPTH=8 entries with pending ops -> iq_full=1; a 9th dispatch is dropped and iq_count=8; then dispatch plus issue in the same cycle keeps iq_count constant.
REQ-025 IQ_AGE_ORDER_EN: dispatch A (entry 0), B, C; free entry 0; dispatch D into entry 0; make all ready -> issue order B, C, D; without the macro -> D, B, C.
REQ-026 Hold alu_ready=0 for 5 cycles with 3 ready entries -> no issue and count=3; flush -> count=0, issue_valid=0, and a same-cycle dispatch is ignored.
